// File: rtl/restador_serial_if.sv
// Start/done handshake, operand and result/flag bundle for the bit-serial subtractor.
// The ALU control FSM drives the master side.
interface restador_serial_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] A_num;
  logic [WIDTH-1:0] B_num;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output start, A_num, B_num,
    input  busy, done, result, borrow_out, flag_n, flag_z, flag_v
  );

  modport slave (
    input  start, A_num, B_num,
    output busy, done, result, borrow_out, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/restador_serial.sv
// Bit-serial WIDTH-bit subtractor A_num - B_num, LSB first, one bit per clock.
// It uses a single registered borrow and reports N/Z/V/borrow flags on completion.
module restador_serial #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  restador_serial_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] shift_a_q,    shift_a_d;
  logic [WIDTH-1:0] shift_b_q,    shift_b_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_q,     borrow_d;
  logic [CW-1:0]    count_q,      count_d;
  logic             a_msb_q,      a_msb_d;
  logic             b_msb_q,      b_msb_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             borrow_out_q, borrow_out_d;
  logic             flag_n_q,     flag_n_d;
  logic             flag_z_q,     flag_z_d;
  logic             flag_v_q,     flag_v_d;

  logic             bit_a, bit_b, diff_bit, borrow_next;
  logic [WIDTH-1:0] diff_next;

  always_comb begin
    bit_a       = shift_a_q[0];
    bit_b       = shift_b_q[0];
    diff_bit    = bit_a ^ bit_b ^ borrow_q;
    borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    diff_next   = {diff_bit, diff_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    shift_a_d    = shift_a_q;
    shift_b_d    = shift_b_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    count_d      = count_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    result_d     = result_q;
    borrow_out_d = borrow_out_q;
    flag_n_d     = flag_n_q;
    flag_z_d     = flag_z_q;
    flag_v_d     = flag_v_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request exactly like IDLE so operations can run back to back.
        if (bus.start) begin
          state_d   = RUN;
          shift_a_d = bus.A_num;
          shift_b_d = bus.B_num;
          a_msb_d   = bus.A_num[WIDTH-1];
          b_msb_d   = bus.B_num[WIDTH-1];
          diff_d    = '0;
          borrow_d  = 1'b0;
          count_d   = '0;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        diff_d    = diff_next;
        borrow_d  = borrow_next;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d      = DONE;
          result_d     = diff_next;
          borrow_out_d = borrow_next;
          flag_n_d     = diff_next[WIDTH-1];
          flag_z_d     = (diff_next == '0);
          flag_v_d     = (a_msb_q != b_msb_q) && (diff_next[WIDTH-1] != a_msb_q);
        end else begin
          count_d      = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_a_q    <= '0;
      shift_b_q    <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      count_q      <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_a_q    <= shift_a_d;
      shift_b_q    <= shift_b_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      count_q      <= count_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      result_q     <= result_d;
      borrow_out_q <= borrow_out_d;
      flag_n_q     <= flag_n_d;
      flag_z_q     <= flag_z_d;
      flag_v_q     <= flag_v_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.flag_n     = flag_n_q;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_v     = flag_v_q;

endmodule
